// File: rtl/write_back_unit_pkg.sv
// rtl/write_back_unit_pkg.sv - shared definitions for the write-back stage
// Purpose: source-index names, PC register default and entry layout helpers.
// Entry layout (LSB first): r7 value, r7_we, reg value, reg_addr, reg_we.
package write_back_unit_pkg;

  // Conventional source ordering on src_data
  localparam int SRC_MEM   = 0;
  localparam int SRC_ALU   = 1;
  localparam int SRC_IMM   = 2;
  localparam int SRC_PCINC = 3;

  localparam int PC_REG_DEF = 7;

  function automatic int wb_r7_val_lsb(input int dw);
    return 0;
  endfunction

  function automatic int wb_r7_we_bit(input int dw);
    return dw;
  endfunction

  function automatic int wb_reg_val_lsb(input int dw);
    return dw + 1;
  endfunction

  function automatic int wb_reg_addr_lsb(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int wb_reg_we_bit(input int dw, input int aw);
    return 2 * dw + 1 + aw;
  endfunction

  // Total entry width (WB_ENTRY_W)
  function automatic int wb_entry_w(input int dw, input int aw);
    return 2 * dw + aw + 2;
  endfunction

endpackage

// File: rtl/write_back_unit_skid_buffer.sv
// rtl/write_back_unit_skid_buffer.sv - two-entry FIFO skid buffer
// Purpose: module wb_skid_buffer, storage, 1-bit read/write pointers and count.
// Ports: push/push_data in, pop in, head_valid/head_data out,
//        count, rd_ptr and both raw entries out for the forwarding lookup.
// Caller guarantees push only when count<2 and pop only when head_valid.
module wb_skid_buffer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [W-1:0]   push_data,
  input  logic           pop,
  output logic           head_valid,
  output logic [W-1:0]   head_data,
  output logic [1:0]     count,
  output logic           rd_ptr,
  output logic [2*W-1:0] ent_data
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign rd_ptr     = rd_ptr_q;
  assign ent_data   = mem_q;

endmodule

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - write-back stage with skid buffer and forwarding
// Purpose: selects GPR/R7 write values from NUM_SRC sources at capture, buffers
//   them in a 2-entry FIFO until the register file accepts them, and offers a
//   forwarding lookup over buffered entries (youngest wins).
// Ports: clk, reset (sync, active-high); in_valid/in_ready/flush handshake;
//   src_data, reg_sel, r7_sel, reg_we, reg_addr, r7_we capture fields;
//   rf_ready, rf_we/rf_addr/rf_data, r7_wen/r7_data register-file side;
//   fwd_addr in, fwd_hit/fwd_data out.
// Option macro WB_RETIRE_CNT_EN adds retire_cnt[31:0], counting accepted,
//   non-flushed inputs (silent retires included).
module write_back_unit
  import write_back_unit_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int REG_AW  = 3,
  parameter int PC_REG  = PC_REG_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          reg_sel,
  input  logic [SEL_W-1:0]          r7_sel,
  input  logic                      reg_we,
  input  logic [REG_AW-1:0]         reg_addr,
  input  logic                      r7_we,
  input  logic                      rf_ready,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic                      r7_wen,
  output logic [DATA_W-1:0]         r7_data,
  input  logic [REG_AW-1:0]         fwd_addr,
  output logic                      fwd_hit,
`ifdef WB_RETIRE_CNT_EN
  output logic [DATA_W-1:0]         fwd_data,
  output logic [31:0]               retire_cnt
`else
  output logic [DATA_W-1:0]         fwd_data
`endif
);

  localparam int EW      = wb_entry_w(DATA_W, REG_AW);
  localparam int R7V_LSB = wb_r7_val_lsb(DATA_W);
  localparam int R7W_BIT = wb_r7_we_bit(DATA_W);
  localparam int RGV_LSB = wb_reg_val_lsb(DATA_W);
  localparam int RGA_LSB = wb_reg_addr_lsb(DATA_W);
  localparam int RGW_BIT = wb_reg_we_bit(DATA_W, REG_AW);

  logic [DATA_W-1:0] reg_val, r7_val;
  logic              st_reg_we;
  logic              accept, push, pop;
  logic              head_valid, hv, rd_ptr;
  logic [EW-1:0]     head, push_data;
  logic [1:0]        count;
  logic [2*EW-1:0]   ent_data;

  // Unmatched select indices (>= NUM_SRC) fall through to zero.
  always_comb begin
    reg_val = '0;
    r7_val  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (reg_sel == SEL_W'(k)) reg_val = src_data[k*DATA_W +: DATA_W];
      if (r7_sel  == SEL_W'(k)) r7_val  = src_data[k*DATA_W +: DATA_W];
    end
  end

  // A GPR write to the PC address loses to a simultaneous R7 write.
  assign st_reg_we = reg_we & ~(r7_we && (reg_addr == REG_AW'(PC_REG)));
  assign push_data = {st_reg_we, reg_addr, reg_val, r7_we, r7_val};

  assign in_ready = (count != 2'd2);
  assign accept   = in_valid & in_ready & ~flush;
  // Writes-nothing entries are accepted but never occupy the buffer.
  assign push     = accept & (st_reg_we | r7_we);
  assign pop      = head_valid & rf_ready & ~reset;

  wb_skid_buffer #(.W(EW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .ent_data   (ent_data)
  );

  // Masking with reset keeps strobes quiet while stale entries are being cleared.
  assign hv      = head_valid & ~reset;
  assign rf_we   = hv & head[RGW_BIT];
  assign r7_wen  = hv & head[R7W_BIT];
  assign rf_addr = hv ? head[RGA_LSB +: REG_AW] : '0;
  assign rf_data = hv ? head[RGV_LSB +: DATA_W] : '0;
  assign r7_data = hv ? head[R7V_LSB +: DATA_W] : '0;

  // Check oldest (head) first, then let the younger entry override.
  always_comb begin
    logic [EW-1:0] e_old, e_new;
    e_old    = ent_data[(rd_ptr ? 1 : 0)*EW +: EW];
    e_new    = ent_data[(rd_ptr ? 0 : 1)*EW +: EW];
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (count != 2'd0 && e_old[RGW_BIT] && e_old[RGA_LSB +: REG_AW] == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = e_old[RGV_LSB +: DATA_W];
    end
    if (count == 2'd2 && e_new[RGW_BIT] && e_new[RGA_LSB +: REG_AW] == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = e_new[RGV_LSB +: DATA_W];
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {31'd0, accept};
  end

  always_ff @(posedge clk) begin
    if (reset) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// tb/tb_write_back_unit.sv - directed self-checking bench for write_back_unit
module tb_write_back_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, reg_we, r7_we, rf_ready;
  logic        in_ready, rf_we, r7_wen, fwd_hit;
  logic [63:0] src_data;
  logic [1:0]  reg_sel, r7_sel;
  logic [2:0]  reg_addr, rf_addr, fwd_addr;
  logic [15:0] rf_data, r7_data, fwd_data;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  write_back_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .src_data(src_data), .reg_sel(reg_sel), .r7_sel(r7_sel),
    .reg_we(reg_we), .reg_addr(reg_addr), .r7_we(r7_we), .rf_ready(rf_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .r7_wen(r7_wen),
    .r7_data(r7_data), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic rw, input logic [2:0] ra,
                     input logic [1:0] rs, input logic r7w, input logic [1:0] r7s);
    in_valid = v;
    reg_we   = rw;
    reg_addr = ra;
    reg_sel  = rs;
    r7_we    = r7w;
    r7_sel   = r7s;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; rf_ready = 1'b0; fwd_addr = 3'd0;
    // {PCINC, IMM, ALU, MEM}
    src_data = {16'h2222, 16'h00AA, 16'h1234, 16'h1111};
    put(0, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    #1;
    // 1. reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_r7_wen", r7_wen, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_r7_data", r7_data, 0);

    // 2. single write r3 <- ALU, one-cycle latency
    rf_ready = 1'b1; fwd_addr = 3'd3;
    put(1, 1, 3, 1, 0, 0);
    #1;
    chk("t2_same_cycle_we", rf_we, 0);
    chk("t2_fwd_not_visible", fwd_hit, 0);
    step();
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_rf_we", rf_we, 1);
    chk("t2_rf_addr", rf_addr, 3);
    chk("t2_rf_data", rf_data, 16'h1234);
    chk("t2_fwd_hit", fwd_hit, 1);
    chk("t2_fwd_data", fwd_data, 16'h1234);
    step();
    chk("t2_drained_we", rf_we, 0);
    chk("t2_drained_data", rf_data, 0);

    // 3. fill while stalled, offer a third, then drain in order
    rf_ready = 1'b0;
    put(1, 1, 1, 0, 0, 0);            // A: r1 <- 1111
    step();
    put(1, 1, 4, 3, 0, 0);            // B: r4 <- 2222
    step();
    put(1, 1, 5, 1, 0, 0);            // C offered while full
    fwd_addr = 3'd4;
    #1;
    chk("t3_full_in_ready", in_ready, 0);
    chk("t3_head_addr", rf_addr, 1);
    chk("t3_head_data", rf_data, 16'h1111);
    chk("t3_fwd_b", fwd_data, 16'h2222);
    fwd_addr = 3'd1;
    #1;
    chk("t3_fwd_a", fwd_data, 16'h1111);
    step();
    put(0, 0, 0, 0, 0, 0);
    rf_ready = 1'b1;
    #1;
    chk("t3_a_addr", rf_addr, 1);
    chk("t3_a_we", rf_we, 1);
    step();
    chk("t3_b_addr", rf_addr, 4);
    chk("t3_b_data", rf_data, 16'h2222);
    chk("t3_in_ready_back", in_ready, 1);
    step();
    chk("t3_empty_we", rf_we, 0);
    chk("t3_c_dropped_addr", rf_addr, 0);

    // 4. two buffered writes to r2, youngest forwards
    rf_ready = 1'b0; fwd_addr = 3'd2;
    src_data[15:0] = 16'd5;
    put(1, 1, 2, 0, 0, 0);
    step();
    src_data[15:0] = 16'd9;
    #1;
    chk("t4_fwd_one", fwd_data, 5);
    step();
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("t4_fwd_hit", fwd_hit, 1);
    chk("t4_fwd_young", fwd_data, 9);
    chk("t4_head_old", rf_data, 5);
    rf_ready = 1'b1;
    step(); step();
    chk("t4_drained", fwd_hit, 0);

    // 5. PC collision: R7 port wins, GPR write dropped
    rf_ready = 1'b0; fwd_addr = 3'd7;
    put(1, 1, 7, 0, 1, 2);
    step();
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("t5_r7_wen", r7_wen, 1);
    chk("t5_r7_data", r7_data, 16'h00AA);
    chk("t5_rf_we", rf_we, 0);
    chk("t5_fwd_pc", fwd_hit, 0);
    // push and pop together at count 1
    rf_ready = 1'b1;
    put(1, 1, 1, 1, 0, 0);
    step();
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("t5_pp_addr", rf_addr, 1);
    chk("t5_pp_data", rf_data, 16'h1234);
    chk("t5_pp_r7", r7_wen, 0);
    chk("t5_pp_ready", in_ready, 1);
    step();
    chk("t5_pp_empty", rf_we, 0);

    // 6. flush and silent retire push nothing
    flush = 1'b1;
    put(1, 1, 3, 1, 1, 1);
    step();
    flush = 1'b0;
    put(1, 0, 3, 1, 0, 1);
    #1;
    chk("t6_flush_we", rf_we, 0);
    chk("t6_flush_r7", r7_wen, 0);
    step();
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_silent_we", rf_we, 0);
    chk("t6_silent_r7", r7_wen, 0);
    chk("t6_silent_ready", in_ready, 1);

    // reset with two entries buffered
    rf_ready = 1'b0;
    put(1, 1, 6, 1, 0, 0);
    step(); step();
    put(0, 0, 0, 0, 0, 0);
    #1;
    chk("t6_full_before_rst", in_ready, 0);
    reset = 1'b1; rf_ready = 1'b1;
    #1;
    chk("t6_rst_cycle_we", rf_we, 0);
    chk("t6_rst_cycle_r7", r7_wen, 0);
    step();
    reset = 1'b0;
    #1;
    chk("t6_post_rst_ready", in_ready, 1);
    chk("t6_post_rst_we", rf_we, 0);
    chk("t6_post_rst_addr", rf_addr, 0);
    step();
    chk("t6_post_rst_still_empty", rf_we, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
